result_vector_writer: RTL and testbench
=======================================

Name: result_vector_writer

Overview:
- Capture-side counterpart of the ROM vector source in the verification environment: stores W-bit DUT results (e.g. natural-log outputs) into an internal 2^AW-entry RAM, one per accepted handshake.
- Entries are written in order from address 0, the same index space as the stimulus ROM, so entry k pairs with stimulus vector k.
- A registered read port lets the bench or checker read captured results back after or during a run.

Parameters:
- W, 32, result data width in bits (32 single, 64 double).
- AW, 10, address width; capture depth = 2^AW = 1024 entries.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; arms capture, clears count.
- stop  input  1  single-cycle pulse; ends capture early.
- in_valid  input  1  result word present on in_data.
- in_data  input  W  result word from DUT.
- in_ready  output  1  writer accepts a word this cycle.
- rd_en  input  1  read request.
- rd_addr  input  AW  read address.
- rd_data  output  W  read result, registered.
- rd_valid  output  1  rd_data updated this cycle.
- wr_count  output  AW+1  number of entries captured, 0..2^AW.
- full  output  1  all 2^AW entries written.
- done  output  1  capture ended (stop or full), held until next start.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; wr_count=0; in_ready=0; full=0; done=0; rd_data=0; rd_valid=0. RAM contents are not cleared. Reset overrides every other input, including mid-capture.
- States: IDLE, CAPTURE, FULL. in_ready=1 only in CAPTURE; it is combinational from state.
- IDLE:
  - start -> CAPTURE; wr_count=0; done=0; full=0.
  - stop is ignored.
- CAPTURE:
  - Write occurs when in_valid & in_ready: mem[wr_count[AW-1:0]] <= in_data; wr_count increments by 1.
  - Write with wr_count = 2^AW-1 -> FULL next cycle: full=1, done=1, wr_count=2^AW.
  - stop (no start) -> IDLE; done=1. A write in the same cycle as stop is still accepted and counted.
  - start -> restart: wr_count=0, done=0. A write in the same cycle is discarded and not counted.
  - start and stop together: start wins.
- FULL:
  - in_ready=0; in_valid is ignored; no wrap-around and no overwrite.
  - start -> CAPTURE with wr_count=0, full=0, done=0. stop is ignored.
- Read port:
  - One-cycle latency: rd_en at edge N gives rd_data and rd_valid=1 after edge N+1. rd_valid=0 in cycles without rd_en.
  - rd_data holds its last value while rd_en=0.
  - If rd_addr >= wr_count (value before that edge's write), rd_data=0. This covers unwritten locations and a read of the location being written in the same cycle.
  - Otherwise rd_data = stored word.
  - Reads are allowed in every state and do not affect capture.
- wr_count is registered and reflects writes accepted up to the previous edge.
- The write port and read port are independent; the RAM is inferable as simple dual-port, and rd_data=0 masking is applied after the RAM read.

Test Plan:
- Reset then idle: rst 2 cycles, in_valid=1, in_data=32'h3F800000 for 5 cycles without start -> in_ready=0, wr_count=0, done=0, rd_data=0.
- Basic capture: start, then 3 words 32'h11111111/22222222/33333333 with in_valid gapped by 1 idle cycle, then stop -> wr_count=3, done=1, state IDLE; rd_addr 0,1,2 -> same words 1 cycle after each rd_en; rd_addr 3 -> 0.
- Full boundary: start, in_valid held high with in_data=index for 1030 cycles -> exactly 1024 accepted, full=1 and in_ready=0 from the cycle after the 1024th write, wr_count=1024, mem[1023]=1023, mem[0]=0 (no wrap).
- Simultaneous events: in CAPTURE with wr_count=5, assert start+stop+in_valid in one cycle -> stays CAPTURE, wr_count=0, done=0, word not stored (rd_addr 0 -> 0). Separately, stop+in_valid with word 32'hDEADBEEF at wr_count=5 -> wr_count=6, mem[5]=32'hDEADBEEF, done=1.
- Read-during-write: in CAPTURE at wr_count=7, rd_en with rd_addr=7 and a write in the same cycle -> rd_data=0; re-read addr 7 next cycle -> written word.
- Reset mid-capture: after 10 writes, assert rst -> wr_count=0, in_ready=0, done=0, rd_valid=0; then start and 1 write -> wr_count=1.

Source files
------------

// File: rtl/result_vector_writer.sv
// result_vector_writer
// Captures W-bit DUT result words into an internal 2^AW-entry RAM, one word
// per accepted handshake, written in order from address 0 so that entry k
// pairs with stimulus vector k. A registered read port returns captured
// words; locations not yet written in the current capture read back as zero.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     pulse: arm capture, clear count (also restarts a capture)
//   stop      pulse: end capture early
//   in_valid  result word present on in_data
//   in_data   result word from DUT
//   in_ready  writer accepts a word this cycle (only while capturing)
//   rd_en     read request
//   rd_addr   read address
//   rd_data   registered read data (zero for unwritten locations)
//   rd_valid  rd_data updated this cycle
//   wr_count  number of entries captured, 0..2^AW
//   full      all 2^AW entries written
//   done      capture ended (stop or full), held until next start
module result_vector_writer #(
  parameter int W  = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic [AW:0]   wr_count,
  output logic          full,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] ZERO     = {(AW+1){1'b0}};

  state_t        state_r;
  state_t        next_state_s;
  logic [AW:0]   wr_count_r;
  logic [AW:0]   next_count_s;
  logic          done_r;
  logic          next_done_s;
  logic          full_r;
  logic          next_full_s;
  logic          wr_en_s;

  logic [W-1:0]  mem_r [0:(1<<AW)-1];
  logic [W-1:0]  rd_word_r;
  logic          rd_mask_r;
  logic          rd_valid_r;

  // Capture state register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wr_count_r <= ZERO;
      done_r     <= 1'b0;
      full_r     <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      wr_count_r <= next_count_s;
      done_r     <= next_done_s;
      full_r     <= next_full_s;
    end
  end

  // Next-state, counter and write-enable decode. A start always wins: it
  // restarts the capture and discards any word offered in the same cycle.
  always_comb begin
    next_state_s = state_r;
    next_count_s = wr_count_r;
    next_done_s  = done_r;
    next_full_s  = full_r;
    wr_en_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_CAPTURE;
          next_count_s = ZERO;
          next_done_s  = 1'b0;
          next_full_s  = 1'b0;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (start) begin
          next_state_s = ST_CAPTURE;
          next_count_s = ZERO;
          next_done_s  = 1'b0;
          next_full_s  = 1'b0;
        end else if (in_valid) begin
          wr_en_s      = 1'b1;
          next_count_s = wr_count_r + ONE;
          // Filling the last slot takes precedence over a simultaneous stop.
          if (wr_count_r == LAST_IDX) begin
            next_state_s = ST_FULL;
            next_full_s  = 1'b1;
            next_done_s  = 1'b1;
          end else if (stop) begin
            next_state_s = ST_IDLE;
            next_done_s  = 1'b1;
          end else begin
            next_state_s = ST_CAPTURE;
          end
        end else if (stop) begin
          next_state_s = ST_IDLE;
          next_done_s  = 1'b1;
        end else begin
          next_state_s = ST_CAPTURE;
        end
      end
      ST_FULL: begin
        if (start) begin
          next_state_s = ST_CAPTURE;
          next_count_s = ZERO;
          next_done_s  = 1'b0;
          next_full_s  = 1'b0;
        end else begin
          next_state_s = ST_FULL;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_count_s = ZERO;
        next_done_s  = 1'b0;
        next_full_s  = 1'b0;
      end
    endcase
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_count_r[AW-1:0]] <= in_data;
    end
  end

  // RAM read port, no reset so it maps onto a plain dual-port RAM.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_word_r <= mem_r[rd_addr];
    end
  end

  // Read qualifiers: the mask hides locations at or beyond the pre-edge
  // count, which also covers a read racing a write to the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_mask_r  <= 1'b1;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_mask_r <= ({1'b0, rd_addr} >= wr_count_r);
      end else begin
        rd_mask_r <= rd_mask_r;
      end
    end
  end

  assign rd_data  = rd_mask_r ? {W{1'b0}} : rd_word_r;
  assign rd_valid = rd_valid_r;
  assign in_ready = (state_r == ST_CAPTURE);
  assign wr_count = wr_count_r;
  assign full     = full_r;
  assign done     = done_r;

endmodule

// File: tb/tb_result_vector_writer.sv
// Directed testbench for result_vector_writer (W=32, AW=10). Inputs change
// 1 ns after each rising edge; outputs are checked at that same point.
module tb_result_vector_writer;

  localparam int W  = 32;
  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic [AW:0]   wr_count;
  logic          full;
  logic          done;

  int checks_cnt;
  int fail_cnt;

  result_vector_writer #(.W(W), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_count (wr_count),
    .full     (full),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic write_word(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check(tag, 64'(rd_data), 64'(exp));
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    in_data = 32'h0; rd_en = 1'b0; rd_addr = 10'd0;

    // Reset then idle with data offered but no start.
    tick(); tick();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    repeat (5) tick();
    in_valid = 1'b0;
    check("idle_ready", 64'(in_ready), 64'd0);
    check("idle_count", 64'(wr_count), 64'd0);
    check("idle_done",  64'(done),     64'd0);
    check("idle_full",  64'(full),     64'd0);
    check("idle_rdata", 64'(rd_data),  64'd0);
    check("idle_rvalid", 64'(rd_valid), 64'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("idle_stop_done", 64'(done), 64'd0);

    // Basic capture with gapped valid, then stop.
    pulse_start();
    check("cap_ready", 64'(in_ready), 64'd1);
    check("cap_count0", 64'(wr_count), 64'd0);
    write_word(32'h11111111); tick();
    write_word(32'h22222222); tick();
    write_word(32'h33333333); tick();
    check("cap_count3", 64'(wr_count), 64'd3);
    check("cap_done_pre", 64'(done), 64'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_done",  64'(done),     64'd1);
    check("stop_ready", 64'(in_ready), 64'd0);
    check("stop_count", 64'(wr_count), 64'd3);
    read_check("rd0", 10'd0, 32'h11111111);
    read_check("rd1", 10'd1, 32'h22222222);
    read_check("rd2", 10'd2, 32'h33333333);
    read_check("rd3", 10'd3, 32'h0);
    read_check("rd2b", 10'd2, 32'h33333333);
    tick();
    check("rd_idle_valid", 64'(rd_valid), 64'd0);
    check("rd_hold", 64'(rd_data), 64'h33333333);

    // Full boundary: valid held high for 1030 cycles.
    pulse_start();
    check("full_restart_done", 64'(done), 64'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 1030; i++) begin
      in_data = 32'(i);
      tick();
      if (i == 1022) begin
        check("pre_full_count", 64'(wr_count), 64'd1023);
        check("pre_full_full",  64'(full),     64'd0);
        check("pre_full_ready", 64'(in_ready), 64'd1);
      end
      if (i == 1023) begin
        check("full_count", 64'(wr_count), 64'd1024);
        check("full_flag",  64'(full),     64'd1);
        check("full_ready", 64'(in_ready), 64'd0);
        check("full_done",  64'(done),     64'd1);
      end
    end
    in_valid = 1'b0;
    check("full_count_end", 64'(wr_count), 64'd1024);
    stop = 1'b1; tick(); stop = 1'b0;
    check("full_stop_ignored", 64'(full), 64'd1);
    read_check("full_rd1023", 10'd1023, 32'd1023);
    read_check("full_rd0",    10'd0,    32'd0);
    read_check("full_rd1",    10'd1,    32'd1);

    // Simultaneous start+stop+valid at count 5: restart, word dropped.
    pulse_start();
    check("sim_full_clr", 64'(full), 64'd0);
    for (int i = 0; i < 5; i++) write_word(32'(100 + i));
    check("sim_count5", 64'(wr_count), 64'd5);
    start = 1'b1; stop = 1'b1; in_valid = 1'b1; in_data = 32'hAAAA5555;
    tick();
    start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    check("sim_count0", 64'(wr_count), 64'd0);
    check("sim_done",   64'(done),     64'd0);
    check("sim_ready",  64'(in_ready), 64'd1);
    read_check("sim_rd0", 10'd0, 32'h0);

    // stop with a write in the same cycle: word kept and counted.
    for (int i = 0; i < 5; i++) write_word(32'(100 + i));
    stop = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    tick();
    stop = 1'b0; in_valid = 1'b0;
    check("stopw_count", 64'(wr_count), 64'd6);
    check("stopw_done",  64'(done),     64'd1);
    check("stopw_ready", 64'(in_ready), 64'd0);
    read_check("stopw_rd5", 10'd5, 32'hDEADBEEF);
    read_check("stopw_rd4", 10'd4, 32'd104);

    // Read-during-write at count 7.
    pulse_start();
    for (int i = 0; i < 7; i++) write_word(32'(200 + i));
    check("rdw_count7", 64'(wr_count), 64'd7);
    in_valid = 1'b1; in_data = 32'hCAFEF00D;
    rd_en = 1'b1; rd_addr = 10'd7;
    tick();
    in_valid = 1'b0; rd_en = 1'b0;
    check("rdw_valid", 64'(rd_valid), 64'd1);
    check("rdw_masked", 64'(rd_data), 64'd0);
    check("rdw_count8", 64'(wr_count), 64'd8);
    read_check("rdw_reread", 10'd7, 32'hCAFEF00D);

    // Reset mid-capture.
    pulse_start();
    for (int i = 0; i < 10; i++) write_word(32'(300 + i));
    check("mid_count10", 64'(wr_count), 64'd10);
    rst = 1'b1; rd_en = 1'b1; rd_addr = 10'd3; in_valid = 1'b1;
    tick();
    rst = 1'b0; rd_en = 1'b0; in_valid = 1'b0;
    check("rst_count",  64'(wr_count), 64'd0);
    check("rst_ready",  64'(in_ready), 64'd0);
    check("rst_done",   64'(done),     64'd0);
    check("rst_full",   64'(full),     64'd0);
    check("rst_rvalid", 64'(rd_valid), 64'd0);
    check("rst_rdata",  64'(rd_data),  64'd0);
    pulse_start();
    write_word(32'h12345678);
    check("post_rst_count", 64'(wr_count), 64'd1);
    read_check("post_rst_rd0", 10'd0, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
